matrix_operand_serializer: RTL and testbench

Upstream feeder for matrix_multiplier. Accepts two N x N operand matrices as parallel element pairs over a valid/ready interface and buffers one complete pair of matrices. Then issues a one-cycle start pulse and streams both matrices bit-serially on A and B, in lock-step, into the multiplier's serial operand inputs. One operand set is in flight at a time; loading the next set is blocked until streaming completes.

---
 rtl/matrix_operand_serializer_if.sv | 24 ++
 rtl/matrix_operand_serializer.sv | 146 ++++++++++++++
 tb/tb_matrix_operand_serializer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_operand_serializer_if.sv
// Element-pair load channel for matrix_operand_serializer.
// The source drives valid and data; the serializer drives ready.
interface matrix_operand_serializer_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        output in_ready
    );
endinterface

// File: rtl/matrix_operand_serializer.sv
// Buffers one N x N operand pair, then streams both matrices LSB-first
// in lock-step behind a one-cycle start pulse.
module matrix_operand_serializer #(
    parameter int N = 2,
    parameter int W = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    matrix_operand_serializer_if.slave    in_if,
    output logic                          start,
    output logic                          A,
    output logic                          B,
    output logic                          busy,
    output logic                          done
);
    localparam int NE = N * N;
    localparam int NB = NE * W;
    localparam int CW = $clog2(NB) + 1;
    localparam int IW = (NE > 1) ? $clog2(NE) : 1;

    typedef enum logic [1:0] {
        S_LOAD,
        S_START,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NE-1:0][W-1:0]   buf_a_q, buf_a_d;
    logic [NE-1:0][W-1:0]   buf_b_q, buf_b_d;
    logic                   start_q, start_d;
    logic                   a_q, a_d;
    logic                   b_q, b_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   accept;
    logic                   last_elem;
    logic                   last_bit;
    logic [NB-1:0]          flat_a;
    logic [NB-1:0]          flat_b;

    assign in_if.in_ready = (state_q == S_LOAD);
    assign accept         = in_if.in_valid && (state_q == S_LOAD);
    assign last_elem      = (idx_q == IW'(NE - 1));
    assign last_bit       = (cnt_q == CW'(NB - 1));

    // Packed row-major storage: stream bit k sits at flat position k.
    assign flat_a = buf_a_q;
    assign flat_b = buf_b_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        buf_a_d = buf_a_q;
        buf_b_d = buf_b_q;
        unique case (state_q)
            S_LOAD: begin
                if (accept) begin
                    for (int i = 0; i < NE; i++) begin
                        if (idx_q == IW'(i)) begin
                            buf_a_d[i] = in_if.in_a;
                            buf_b_d[i] = in_if.in_b;
                        end
                    end
                    if (last_elem) begin
                        idx_d   = '0;
                        state_d = S_START;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (last_bit) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_LOAD;
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        start_d = (state_d == S_START);
        busy_d  = (state_d == S_START) || (state_d == S_SHIFT);
        done_d  = (state_d == S_DONE);
        a_d     = 1'b0;
        b_d     = 1'b0;
        if (state_d == S_SHIFT) begin
            for (int i = 0; i < NB; i++) begin
                if (cnt_d == CW'(i)) begin
                    a_d = flat_a[i];
                    b_d = flat_b[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOAD;
            idx_q   <= '0;
            cnt_q   <= '0;
            buf_a_q <= '0;
            buf_b_q <= '0;
            start_q <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            buf_a_q <= buf_a_d;
            buf_b_q <= buf_b_d;
            start_q <= start_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign start = start_q;
    assign A     = a_q;
    assign B     = b_q;
    assign busy  = busy_q;
    assign done  = done_q;
endmodule

// File: tb/tb_matrix_operand_serializer.sv
// Scoreboard bench for matrix_operand_serializer (N=2, W=8).
// Stimulus queues expected serial bits; a negedge monitor checks them.
module tb_matrix_operand_serializer;
    localparam int N  = 2;
    localparam int W  = 8;
    localparam int NE = N * N;
    localparam int NB = NE * W;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic sa;
    logic sb;
    logic busy;
    logic done;

    always #5 clk = ~clk;

    matrix_operand_serializer_if #(.W(W)) bus ();

    matrix_operand_serializer #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .in_if (bus),
        .start (start),
        .A     (sa),
        .B     (sb),
        .busy  (busy),
        .done  (done)
    );

    typedef struct packed {
        logic a;
        logic b;
    } bits_t;

    bits_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;
    bit    in_stream = 1'b0;
    int    shift_n   = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_set(input logic [W-1:0] a[NE],
                            input logic [W-1:0] b[NE]);
        bits_t e;
        for (int i = 0; i < NE; i++) begin
            for (int k = 0; k < W; k++) begin
                e.a = a[i][k];
                e.b = b[i][k];
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        while (!bus.in_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=not_ready required=ready");
        end
        tick();
        bus.in_valid = 1'b0;
        bus.in_a     = W'($urandom);
        bus.in_b     = W'($urandom);
    endtask

    task automatic load_set(input logic [W-1:0] a[NE],
                            input logic [W-1:0] b[NE], input int gap);
        push_set(a, b);
        for (int i = 0; i < NE; i++) begin
            send(a[i], b[i]);
            if (i < NE - 1) begin
                for (int g = 0; g < gap; g++) begin
                    chk("gap_no_start", 32'(start), 0);
                    tick();
                end
            end
        end
        chk("start_after_last", 32'(start), 1);
        chk("ready_low_start", 32'(bus.in_ready), 0);
    endtask

    // Optionally keeps in_valid high with changing junk until done.
    task automatic wait_done(input bit junk);
        int n = 1;
        bus.in_valid = junk;
        while (!done && n < 100) begin
            if (junk) begin
                bus.in_a = W'($urandom);
                bus.in_b = W'($urandom);
            end
            tick();
            n++;
        end
        chk("done_latency", n, NB + 2);
        chk("queue_drained", exp_q.size(), 0);
        tick();
    endtask

    always @(negedge clk) begin
        bits_t e;
        if (rst) begin
            in_stream = 1'b0;
            shift_n   = 0;
        end else if (start) begin
            chk("start_ab", 32'({sa, sb}), 0);
            chk("start_busy", 32'(busy), 1);
            in_stream = 1'b1;
            shift_n   = 0;
        end else if (busy) begin
            chk("shift_ready", 32'(bus.in_ready), 0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL shift_unexpected actual=bit required=none");
            end else begin
                e = exp_q.pop_front();
                chk("shift_a", 32'(sa), 32'(e.a));
                chk("shift_b", 32'(sb), 32'(e.b));
            end
            shift_n++;
        end else if (done) begin
            chk("done_in_stream", 32'(in_stream), 1);
            chk("done_nbits", shift_n, NB);
            chk("done_ab", 32'({sa, sb}), 0);
            chk("done_ready", 32'(bus.in_ready), 0);
            in_stream = 1'b0;
        end else begin
            chk("idle_ab", 32'({sa, sb}), 0);
            chk("idle_ready", 32'(bus.in_ready), 1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] a1[NE];
        logic [W-1:0] b1[NE];
        logic [W-1:0] a2[NE];
        logic [W-1:0] b2[NE];
        logic [W-1:0] a3[NE];
        logic [W-1:0] b3[NE];
        logic [W-1:0] a4[NE];
        a1 = '{8'h01, 8'h02, 8'h03, 8'h04};
        b1 = '{8'h05, 8'h06, 8'h07, 8'h08};
        a2 = '{8'h5A, 8'hC3, 8'h0F, 8'h81};
        b2 = '{8'h11, 8'h22, 8'h44, 8'h88};
        a3 = '{8'hFF, 8'h00, 8'h00, 8'h00};
        b3 = '{8'h00, 8'h00, 8'h00, 8'hFF};
        a4 = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        tick();
        tick();
        chk("rst_ready", 32'(bus.in_ready), 1);
        chk("rst_outs", 32'({start, busy, done, sa, sb}), 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_outs", 32'({start, busy, done, sa, sb}), 0);
        end

        // basic back-to-back load
        load_set(a1, b1, 0);
        wait_done(1'b0);

        // backpressure: junk held valid through the stream
        load_set(a1, b1, 0);
        wait_done(1'b1);
        load_set(a2, b2, 0);
        wait_done(1'b0);

        // gapped loading
        load_set(a1, b1, 3);
        wait_done(1'b0);

        // reset during SHIFT cycle 10
        load_set(a1, b1, 0);
        for (int i = 0; i < 11; i++) tick();
        chk("pre_rst_busy", 32'(busy), 1);
        rst = 1'b1;
        tick();
        exp_q.delete();
        chk("mid_rst_outs", 32'({start, busy, done, sa, sb}), 0);
        chk("mid_rst_ready", 32'(bus.in_ready), 1);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_no_done", 32'(done), 0);
        end
        load_set(a3, b3, 0);
        wait_done(1'b0);

        // all ones
        load_set(a4, a4, 0);
        wait_done(1'b0);

        for (int i = 0; i < 3; i++) tick();
        chk("final_queue", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
